// File: rtl/raid_pkg.sv
// Shared RAID definitions for the stripe read path: disk count, FSM states,
// slot mapping under rotating parity and the mod-3 reduction step.
package raid_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_DISKS = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  typedef logic [1:0] disk_idx_t;

  typedef enum logic [1:0] {
    SLOT_A = 2'd0,
    SLOT_B = 2'd1,
    SLOT_P = 2'd2
  } slot_t;

  // The parity disk fills SLOT_P; the lower-numbered data disk goes to SLOT_A.
  function automatic slot_t slot_of(input disk_idx_t pd, input disk_idx_t disk);
    slot_t s;
    if (disk == pd) begin
      s = SLOT_P;
    end else if ((disk == 2'd0) || ((disk == 2'd1) && (pd == 2'd0))) begin
      s = SLOT_A;
    end else begin
      s = SLOT_B;
    end
    return s;
  endfunction

  function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic bit_in);
    logic [1:0] r;
    case ({rem, bit_in})
      3'd0:    r = 2'd0;
      3'd1:    r = 2'd1;
      3'd2:    r = 2'd2;
      3'd3:    r = 2'd0;
      3'd4:    r = 2'd1;
      3'd5:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/parity_disk_sel.sv
// Combinational mod-3 reduction of a stripe address, giving the parity disk index.
// Shared by the read-side assembler and the write-path parity generator.
module parity_disk_sel
  import raid_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output disk_idx_t         pd
);

  logic [1:0] rem_s;

  // Horner-style reduction, MSB first: rem = (2*rem + bit) mod 3.
  always_comb begin
    rem_s = 2'd0;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      rem_s = mod3_step(rem_s, addr[i]);
    end
    pd = rem_s;
  end

endmodule

// File: rtl/stripe_assembler.sv
// Fetches one stripe from three disks, reorders the out-of-order responses into
// data/parity slots under rotating parity, and presents them with valid/ready.
module stripe_assembler
  import raid_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] stripe_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        rd_req,
  input  logic [2:0]        rd_valid,
  input  logic [WIDTH-1:0]  rd_data0,
  input  logic [WIDTH-1:0]  rd_data1,
  input  logic [WIDTH-1:0]  rd_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  data_a,
  output logic [WIDTH-1:0]  data_b,
  output logic [WIDTH-1:0]  parity_word,
  output logic [1:0]        parity_disk,
  output logic              out_err,
  output logic [2:0]        missing
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_r;
  logic              busy_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [2:0]        rd_req_r;
  logic [2:0]        captured_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  data_a_r;
  logic [WIDTH-1:0]  data_b_r;
  logic [WIDTH-1:0]  parity_word_r;
  disk_idx_t         parity_disk_r;
  logic              out_err_r;
  logic [2:0]        missing_r;

  disk_idx_t         pd_s;
  logic [2:0]        cap_s;
  logic [2:0]        cap_done_s;
  logic [WIDTH-1:0]  rd_word_s [NUM_DISKS];

  parity_disk_sel #(.ADDR_W(ADDR_W)) u_pd_sel (
    .addr (stripe_addr),
    .pd   (pd_s)
  );

  assign rd_word_s[0] = rd_data0;
  assign rd_word_s[1] = rd_data1;
  assign rd_word_s[2] = rd_data2;

  // rd_req doubles as the "still wanted" mask, so late or duplicate strobes fall out here.
  assign cap_s      = rd_valid & rd_req_r;
  assign cap_done_s = captured_r | cap_s;

  // Stripe FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      rd_addr_r     <= {ADDR_W{1'b0}};
      rd_req_r      <= 3'b000;
      captured_r    <= 3'b000;
      cnt_r         <= {CNT_W{1'b0}};
      out_valid_r   <= 1'b0;
      data_a_r      <= {WIDTH{1'b0}};
      data_b_r      <= {WIDTH{1'b0}};
      parity_word_r <= {WIDTH{1'b0}};
      parity_disk_r <= 2'd0;
      out_err_r     <= 1'b0;
      missing_r     <= 3'b000;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r       <= COLLECT;
            busy_r        <= 1'b1;
            rd_addr_r     <= stripe_addr;
            rd_req_r      <= 3'b111;
            captured_r    <= 3'b000;
            cnt_r         <= {CNT_W{1'b0}};
            parity_disk_r <= pd_s;
            data_a_r      <= {WIDTH{1'b0}};
            data_b_r      <= {WIDTH{1'b0}};
            parity_word_r <= {WIDTH{1'b0}};
            out_err_r     <= 1'b0;
            missing_r     <= 3'b000;
          end
        end

        COLLECT: begin
          for (int i = 0; i < NUM_DISKS; i++) begin
            if (cap_s[i]) begin
              case (slot_of(parity_disk_r, disk_idx_t'(i)))
                SLOT_A:  data_a_r      <= rd_word_s[i];
                SLOT_B:  data_b_r      <= rd_word_s[i];
                SLOT_P:  parity_word_r <= rd_word_s[i];
                default: ;
              endcase
            end
          end
          captured_r <= cap_done_s;
          if (cap_done_s == 3'b111) begin
            state_r     <= PRESENT;
            rd_req_r    <= 3'b000;
            out_valid_r <= 1'b1;
          end else if (cnt_r == CNT_MAX) begin
            // Captures landing in the expiry cycle still count.
            state_r     <= PRESENT;
            rd_req_r    <= 3'b000;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b1;
            missing_r   <= ~cap_done_s;
          end else begin
            rd_req_r <= rd_req_r & ~cap_s;
            cnt_r    <= cnt_r + CNT_W'(1);
          end
        end

        PRESENT: begin
          if (out_ready) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end

        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          rd_req_r    <= 3'b000;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign rd_addr     = rd_addr_r;
  assign rd_req      = rd_req_r;
  assign out_valid   = out_valid_r;
  assign data_a      = data_a_r;
  assign data_b      = data_b_r;
  assign parity_word = parity_word_r;
  assign parity_disk = parity_disk_r;
  assign out_err     = out_err_r;
  assign missing     = missing_r;

endmodule

// File: tb/tb_stripe_assembler.sv
// Bench for stripe_assembler: directed scenarios plus random stripes checked
// against a cycle-level model of disk responses and slot placement.
module tb_stripe_assembler;

  localparam int WIDTH   = 32;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              n_rst;
  logic              start;
  logic [ADDR_W-1:0] stripe_addr;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_req;
  logic [2:0]        rd_valid;
  logic [WIDTH-1:0]  rd_data0, rd_data1, rd_data2;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  data_a, data_b, parity_word;
  logic [1:0]        parity_disk;
  logic              out_err;
  logic [2:0]        missing;

  logic [WIDTH-1:0]  dd [3];
  int                k_m [3];
  logic [WIDTH-1:0]  w_m [3];
  logic              dup_m;

  int checks = 0;
  int errors = 0;

  assign rd_data0 = dd[0];
  assign rd_data1 = dd[1];
  assign rd_data2 = dd[2];

  stripe_assembler #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .stripe_addr (stripe_addr),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_a      (data_a),
    .data_b      (data_b),
    .parity_word (parity_word),
    .parity_disk (parity_disk),
    .out_err     (out_err),
    .missing     (missing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Disk i answers once at cycle k_m[i] (relative to start) and optionally repeats one cycle later.
  task automatic drive_cycle(input int j);
    for (int i = 0; i < 3; i++) begin
      rd_valid[i] = (j == k_m[i]) || (dup_m && (j == k_m[i] + 1));
      dd[i]       = (j == k_m[i]) ? w_m[i] : $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_rd_req"}, rd_req, 0);
    check_val({tag, "_rd_addr"}, rd_addr, 0);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_err"}, out_err, 0);
    check_val({tag, "_missing"}, missing, 0);
    check_val({tag, "_data_a"}, data_a, 0);
    check_val({tag, "_data_b"}, data_b, 0);
    check_val({tag, "_parity_word"}, parity_word, 0);
    check_val({tag, "_parity_disk"}, parity_disk, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_stripe(input logic [15:0] addr, input int k0, input int k1, input int k2,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic dup, input int rdy_wait, input logic start_in_wait);
    int pd, ad, bd, done_j, kmax, j;
    logic [2:0]  miss, exp_req;
    logic [31:0] slot_val [3];
    k_m[0] = k0; k_m[1] = k1; k_m[2] = k2;
    w_m[0] = w0; w_m[1] = w1; w_m[2] = w2;
    dup_m  = dup;
    pd = int'(addr) % 3;
    case (pd)
      0:       begin ad = 1; bd = 2; end
      1:       begin ad = 0; bd = 2; end
      default: begin ad = 0; bd = 1; end
    endcase
    kmax = 0;
    for (int i = 0; i < 3; i++) begin
      miss[i]     = (k_m[i] > TIMEOUT);
      slot_val[i] = miss[i] ? 32'd0 : w_m[i];
      if (k_m[i] > kmax) kmax = k_m[i];
    end
    done_j = (miss == 3'b000) ? kmax + 1 : TIMEOUT + 1;

    check_val("idle_busy", busy, 0);
    start = 1'b1;
    stripe_addr = addr;
    drive_cycle(0);
    for (j = 1; j < done_j; j++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) exp_req[i] = (k_m[i] >= j);
      check_val("collect_busy", busy, 1);
      check_val("collect_rd_addr", rd_addr, addr);
      check_val("collect_rd_req", rd_req, exp_req);
      check_val("collect_out_valid", out_valid, 0);
      start = 1'b0;
      drive_cycle(j);
    end
    @(negedge clk);
    j = done_j;
    check_val("present_out_valid", out_valid, 1);
    check_val("present_data_a", data_a, slot_val[ad]);
    check_val("present_data_b", data_b, slot_val[bd]);
    check_val("present_parity_word", parity_word, slot_val[pd]);
    check_val("present_parity_disk", parity_disk, pd);
    check_val("present_out_err", out_err, |miss);
    check_val("present_missing", missing, miss);
    check_val("present_rd_req", rd_req, 0);
    for (int n = 0; n < rdy_wait; n++) begin
      out_ready   = 1'b0;
      start       = start_in_wait;
      stripe_addr = ~addr;
      drive_cycle(j);
      @(negedge clk);
      j++;
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_data_a", data_a, slot_val[ad]);
      check_val("hold_data_b", data_b, slot_val[bd]);
      check_val("hold_parity_word", parity_word, slot_val[pd]);
      check_val("hold_missing", missing, miss);
      check_val("hold_rd_addr", rd_addr, addr);
      check_val("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    start     = 1'b0;
    drive_cycle(j);
    @(negedge clk);
    check_val("done_out_valid", out_valid, 0);
    check_val("done_busy", busy, 0);
    check_val("done_rd_req", rd_req, 0);
    out_ready = 1'b0;
    rd_valid  = 3'b000;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; stripe_addr = '0; rd_valid = 3'b000;
    out_ready = 1'b0; dup_m = 1'b0;
    for (int i = 0; i < 3; i++) begin dd[i] = '0; k_m[i] = 0; w_m[i] = '0; end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Ordered response, all disks in the first COLLECT cycle.
    run_stripe(16'h0004, 1, 1, 1, 32'h11111111, 32'h33333333, 32'h22222222, 1'b0, 0, 1'b0);
    // Out-of-order: disk2, disk0 three cycles later, then disk1, with duplicates.
    run_stripe(16'h0003, 4, 5, 1, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 1'b1, 0, 1'b0);
    // Backpressure with an ignored start in the window; the next stripe starts right after.
    run_stripe(16'h0010, 2, 1, 3, $urandom, $urandom, $urandom, 1'b0, 5, 1'b1);
    // Timeout with disk1 silent; its late strobe lands while presenting.
    run_stripe(16'h0005, 1, TIMEOUT + 2, 2, $urandom, $urandom, $urandom, 1'b0, 2, 1'b0);
    // Boundary address and a capture in the expiry cycle.
    run_stripe(16'hFFFF, 3, TIMEOUT, 1, $urandom, $urandom, $urandom, 1'b0, 0, 1'b0);
    // Everything missing.
    run_stripe(16'h1234, TIMEOUT + 1, TIMEOUT + 2, TIMEOUT + 1, $urandom, $urandom, $urandom, 1'b0, 1, 1'b0);

    // Reset in the middle of COLLECT, after one capture.
    start = 1'b1; stripe_addr = 16'h0007;
    k_m[0] = 1; k_m[1] = 50; k_m[2] = 50; w_m[0] = 32'hDEADBEEF; dup_m = 1'b0;
    drive_cycle(0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      drive_cycle(j);
    end
    n_rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    n_rst = 1'b1;
    rd_valid = 3'b111; dd[0] = 32'h12345678; dd[1] = 32'h9ABCDEF0; dd[2] = 32'h0F0F0F0F;
    @(negedge clk);
    rd_valid = 3'b000;
    check_all_zero("postreset");
    @(negedge clk);

    // Random stripes.
    for (int t = 0; t < 40; t++) begin
      run_stripe(16'($urandom), $urandom_range(1, TIMEOUT + 2), $urandom_range(1, TIMEOUT + 2),
                 $urandom_range(1, TIMEOUT + 2), $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stripe_assembler.md
# stripe_assembler

- Sits directly upstream of the parity checker.
- For one stripe address, it requests a word from each of the three member disks and collects the responses, which may arrive out of order.
- It then reorders the words so the two data words and the parity word land in fixed slots under RAID5 rotating parity.
- It presents the aligned stripe with a valid/ready handshake, or flags a per-disk timeout.

## Interface
Parameters:
- WIDTH, 32, word width of every disk read and every output word
- ADDR_W, 16, stripe address width
- TIMEOUT, 64, max cycles in COLLECT before the missing disks are flagged; legal range 2..65535

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  system clock
  - n_rst  in  1  synchronous active-low reset
- Command:
  - start  in  1  command strobe; sampled only in IDLE
  - stripe_addr  in  ADDR_W  stripe to fetch; sampled with start
  - busy  out  1  high in every state except IDLE
- Disk read channels:
  - rd_addr  out  ADDR_W  latched stripe address, shared by all disks
  - rd_req  out  3  per-disk request; bit i is disk i
  - rd_valid  in  3  per-disk response strobe
  - rd_data0, rd_data1, rd_data2  in  WIDTH each  response data from disks 0, 1, 2
- Output stripe:
  - out_valid  out  1  aligned stripe available
  - out_ready  in  1  downstream accepts
  - data_a, data_b  out  WIDTH each  the two data words
  - parity_word  out  WIDTH  parity word
  - parity_disk  out  2  index of the disk holding parity
  - out_err  out  1  stripe incomplete due to timeout
  - missing  out  3  disks that did not respond

## Operation
- **Parity disk rule:** pd = stripe_addr mod 3, computed over the full ADDR_W width.
- **Slot mapping:**
  - pd=0: a=disk1, b=disk2, p=disk0
  - pd=1: a=disk0, b=disk2, p=disk1
  - pd=2: a=disk0, b=disk1, p=disk2
- **Downstream contract:** data_a ^ data_b == parity_word on a consistent stripe.
- **FSM states:** IDLE, COLLECT, PRESENT.
- **IDLE:**
  - On start, latch stripe_addr into rd_addr and latch pd.
  - Clear the capture mask and the timeout counter.
  - Set rd_req=3'b111 and go to COLLECT.
- **COLLECT:**
  - rd_req[i] stays high until disk i is captured.
  - When rd_valid[i] && rd_req[i], register that disk's word into its slot, set captured[i] and drop rd_req[i] on the next edge.
  - rd_valid[i] while rd_req[i] is low is ignored (late or duplicate responses).
  - When all three disks are captured, go to PRESENT with out_err=0 and missing=0.
  - The counter increments each COLLECT cycle. When it reaches TIMEOUT-1 with any disk uncaptured:
    - missing = ~captured (after this cycle's captures), out_err=1.
    - Uncaptured slots read 0.
    - Drop all rd_req and go to PRESENT.
- **PRESENT:**
  - out_valid high; outputs are stable while out_valid && !out_ready.
  - On out_ready, go to IDLE and drop out_valid.
- **start while busy** is ignored; there is no queueing.
- **Simultaneous events:** a capture in the timeout-expiry cycle counts as captured. If that completes the stripe, out_err=0.
- **Reset:**
  - Every output is 0: busy, rd_req, rd_addr, out_valid, out_err, missing, data_a, data_b, parity_word, parity_disk.
  - FSM returns to IDLE.
  - Reset mid-COLLECT abandons the stripe; later responses are ignored because rd_req=0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- start in cycle N: busy and rd_req=111 are visible in N+1.
- Best case, all rd_valid in N+1: out_valid in N+2, so stripe latency is 2 cycles.
- Earliest start after a handshake: an out_ready handshake in cycle M returns to IDLE at M+1, and a new start is accepted in M+1. Throughput is therefore at most one stripe per 3 cycles.
- Timeout: COLLECT is entered at N+1, and out_valid with out_err rises TIMEOUT cycles later, at N+1+TIMEOUT.

## Structure
- **Shared package raid_pkg:**
  - WORD_W=32 and NUM_DISKS=3 constants.
  - State enum {IDLE, COLLECT, PRESENT}.
  - disk_idx_t (2-bit).
- **Sub-module parity_disk_sel:** combinational ADDR_W-bit mod-3 reduction, so pd = stripe_addr mod 3. It is also reusable by the write-path parity generator.
- **Timeout counter:** width $clog2(TIMEOUT).

## Test plan
- **Ordered response:** stripe_addr=0x0004 (pd=1); disks 0/1/2 return 0x11111111/0x33333333/0x22222222 in the same cycle. Expect out_valid two cycles after start with a=0x11111111, b=0x22222222, p=0x33333333, parity_disk=1, out_err=0.
- **Out-of-order response:** stripe_addr=0x0003 (pd=0); responses arrive disk2, then disk0 three cycles later, then disk1. Expect rd_req to drop per disk; a=disk1, b=disk2, p=disk0.
- **Backpressure:** out_ready held low 5 cycles. Expect outputs stable, and a start pulse during this window ignored (rd_addr unchanged). out_ready high completes, and the next start is accepted one cycle later.
- **Timeout:** TIMEOUT=8, disk1 never responds. Expect out_valid at start+9 with out_err=1, missing=3'b010, data slot from disk1 = 0. A late rd_valid[1] after this is ignored.
- **Boundary:** stripe_addr=0xFFFF yields parity_disk=0. A capture coinciding with the expiry cycle completes with out_err=0.
- **Reset:** n_rst low mid-COLLECT. Expect all outputs 0 the next cycle and a return to IDLE. A subsequent rd_valid produces no capture.
